// File: rtl/fb_write_queue.sv
// rtl/fb_write_queue.sv - framebuffer write queue
// Buffers toggle-signalled RAM writes and drains them to the framebuffer port when fb_ready is high.
module fb_write_queue #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int FIFO_DEPTH      = 8,
  localparam int ADDR_W = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL),
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              wr_toggle,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [7:0]        wr_data,
  input  logic              fb_ready,
  output logic              fb_write,
  output logic [ADDR_W-1:0] fb_address,
  output logic [7:0]        fb_data,
  input  logic              clear_overflow,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 8;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic              toggle_q, toggle_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              fb_write_q, fb_write_d;
  logic [ADDR_W-1:0] fb_address_q, fb_address_d;
  logic [7:0]        fb_data_q, fb_data_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  always_comb begin
    toggle_d     = wr_toggle;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    fb_write_d   = 1'b0;
    fb_address_d = fb_address_q;
    fb_data_d    = fb_data_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;

    push_req = (wr_toggle != toggle_q) & wr_enable;
    full     = (level_q == FULL_LVL);
    pop      = (level_q != '0) & fb_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    push_ok  = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {wr_address, wr_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      {fb_address_d, fb_data_d} = mem_q[rd_ptr_q];
      fb_write_d                = 1'b1;
      rd_ptr_d                  = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end

    busy_d = (level_d != '0) | fb_write_d;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      toggle_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      fb_write_q   <= 1'b0;
      fb_address_q <= '0;
      fb_data_q    <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      toggle_q     <= toggle_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      fb_write_q   <= fb_write_d;
      fb_address_q <= fb_address_d;
      fb_data_q    <= fb_data_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign fb_write   = fb_write_q;
  assign fb_address = fb_address_q;
  assign fb_data    = fb_data_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fb_write_queue.sv
// tb/tb_fb_write_queue.sv - self-checking bench for fb_write_queue
// Cycle table for reset/single/stall/qualifier cases, then hand sequences for overflow, full and wrap.
module tb_fb_write_queue;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        wr_toggle;
  logic        wr_enable;
  logic [11:0] wr_address;
  logic [7:0]  wr_data;
  logic        fb_ready;
  logic        fb_write;
  logic [11:0] fb_address;
  logic [7:0]  fb_data;
  logic        clear_overflow;
  logic        overflow;
  logic [3:0]  fifo_level;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic        mon_en = 1'b0;
  logic [19:0] exp_q [$];

  always #5 clk_in = ~clk_in;

  fb_write_queue dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .wr_toggle      (wr_toggle),
    .wr_enable      (wr_enable),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .fb_ready       (fb_ready),
    .fb_write       (fb_write),
    .fb_address     (fb_address),
    .fb_data        (fb_data),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  typedef struct {
    logic        rst, flip, en;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        rdy, clr;
    logic        e_wr;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    logic [3:0]  e_lvl;
    logic        e_ov, e_busy;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic rst, input logic flip, input logic en,
                              input logic [11:0] addr, input logic [7:0] data,
                              input logic rdy, input logic clr, input logic e_wr,
                              input logic [11:0] e_addr, input logic [7:0] e_data,
                              input logic [3:0] e_lvl, input logic e_ov, input logic e_busy);
    vec_t v;
    v.rst = rst; v.flip = flip; v.en = en; v.addr = addr; v.data = data;
    v.rdy = rdy; v.clr = clr; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_lvl = e_lvl; v.e_ov = e_ov; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [11:0] addr, input logic [7:0] data);
    wr_toggle  = ~wr_toggle;
    wr_enable  = 1'b1;
    wr_address = addr;
    wr_data    = data;
    step();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    step();
    chk({name, "_wr_after"}, fb_write, 0);
    chk({name, "_lvl_after"}, fifo_level, 0);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  always @(negedge clk_in) begin : monitor
    logic [19:0] e;
    if (mon_en && fb_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none", {fb_address, fb_data});
      end else begin
        e = exp_q.pop_front();
        chk("write_order", {12'h0, fb_address, fb_data}, {12'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_toggle = 1'b0; wr_enable = 1'b0; wr_address = '0; wr_data = '0;
    fb_ready = 1'b0; clear_overflow = 1'b0;

    //           rst flip en addr    data   rdy clr  wr e_addr  e_data lvl ov busy
    vt[0]  = mk(1, 1, 1, 12'h123, 8'h11, 1, 0,  0, 12'h000, 8'h00, 0, 0, 0);
    vt[1]  = mk(1, 1, 1, 12'h124, 8'h12, 1, 0,  0, 12'h000, 8'h00, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 12'h000, 8'h00, 1, 0,  0, 12'h000, 8'h00, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 12'h000, 8'h00, 1, 0,  0, 12'h000, 8'h00, 0, 0, 0);
    vt[4]  = mk(0, 1, 1, 12'h07F, 8'hA5, 1, 0,  0, 12'h000, 8'h00, 1, 0, 1);
    vt[5]  = mk(0, 0, 1, 12'h07F, 8'hA5, 1, 0,  1, 12'h07F, 8'hA5, 0, 0, 1);
    vt[6]  = mk(0, 0, 1, 12'h07F, 8'hA5, 1, 0,  0, 12'h07F, 8'hA5, 0, 0, 0);
    vt[7]  = mk(0, 1, 1, 12'h101, 8'h01, 0, 0,  0, 12'h07F, 8'hA5, 1, 0, 1);
    vt[8]  = mk(0, 1, 1, 12'h102, 8'h02, 0, 0,  0, 12'h07F, 8'hA5, 2, 0, 1);
    vt[9]  = mk(0, 1, 1, 12'h103, 8'h03, 0, 0,  0, 12'h07F, 8'hA5, 3, 0, 1);
    vt[10] = mk(0, 1, 1, 12'h104, 8'h04, 0, 0,  0, 12'h07F, 8'hA5, 4, 0, 1);
    vt[11] = mk(0, 1, 1, 12'h105, 8'h05, 0, 0,  0, 12'h07F, 8'hA5, 5, 0, 1);
    vt[12] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  1, 12'h101, 8'h01, 4, 0, 1);
    vt[13] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  1, 12'h102, 8'h02, 3, 0, 1);
    vt[14] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  1, 12'h103, 8'h03, 2, 0, 1);
    vt[15] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  1, 12'h104, 8'h04, 1, 0, 1);
    vt[16] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  1, 12'h105, 8'h05, 0, 0, 1);
    vt[17] = mk(0, 0, 1, 12'h105, 8'h05, 1, 0,  0, 12'h105, 8'h05, 0, 0, 0);
    vt[18] = mk(0, 1, 0, 12'h200, 8'h77, 0, 0,  0, 12'h105, 8'h05, 0, 0, 0);
    vt[19] = mk(0, 1, 1, 12'h201, 8'h78, 0, 0,  0, 12'h105, 8'h05, 1, 0, 1);
    vt[20] = mk(0, 0, 1, 12'h201, 8'h78, 0, 0,  0, 12'h105, 8'h05, 1, 0, 1);
    vt[21] = mk(0, 0, 1, 12'h201, 8'h78, 1, 0,  1, 12'h201, 8'h78, 0, 0, 1);
    vt[22] = mk(0, 0, 1, 12'h201, 8'h78, 1, 0,  0, 12'h201, 8'h78, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      reset          = vt[i].rst;
      if (vt[i].flip) wr_toggle = ~wr_toggle;
      wr_enable      = vt[i].en;
      wr_address     = vt[i].addr;
      wr_data        = vt[i].data;
      fb_ready       = vt[i].rdy;
      clear_overflow = vt[i].clr;
      step();
      chk($sformatf("v%0d_fb_write", i), fb_write, vt[i].e_wr);
      chk($sformatf("v%0d_fb_address", i), fb_address, vt[i].e_addr);
      chk($sformatf("v%0d_fb_data", i), fb_data, vt[i].e_data);
      chk($sformatf("v%0d_level", i), fifo_level, vt[i].e_lvl);
      chk($sformatf("v%0d_overflow", i), overflow, vt[i].e_ov);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
    end

    mon_en = 1'b1;

    // Overflow: ten writes into a stalled depth-8 queue, entries 9 and 10 are lost.
    fb_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push(12'h300 + 12'(i), 8'(i));
      if (i == 8) begin
        chk("ovf_lvl8", fifo_level, 8);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_lvl_full", fifo_level, 8);
    chk("ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) exp_q.push_back({12'h300 + 12'(i), 8'(i)});
    fb_ready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Clear and drop in the same cycle: the drop wins.
    fb_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(12'h400 + 12'(i), 8'h60 + 8'(i));
      exp_q.push_back({12'h400 + 12'(i), 8'h60 + 8'(i)});
    end
    clear_overflow = 1'b1;
    push(12'h4FF, 8'hEE);
    clear_overflow = 1'b0;
    chk("clr_vs_drop", overflow, 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clr_after", overflow, 0);
    fb_ready = 1'b1;
    drain("clr_drain");

    // Full queue with a simultaneous pop accepts the new entry behind the older eight.
    fb_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(12'h500 + 12'(i), 8'h40 + 8'(i));
      exp_q.push_back({12'h500 + 12'(i), 8'h40 + 8'(i)});
    end
    chk("full_lvl", fifo_level, 8);
    exp_q.push_back({12'h5FF, 8'h99});
    fb_ready = 1'b1;
    push(12'h5FF, 8'h99);
    chk("full_sim_lvl", fifo_level, 8);
    chk("full_sim_ov", overflow, 0);
    chk("full_sim_wr", fb_write, 1);
    drain("full_drain");

    // Wrap: twenty writes with fb_ready low every third cycle.
    for (int i = 0; i < 20; i++) exp_q.push_back({12'h600 + 12'(i), 8'h80 + 8'(i)});
    for (int j = 0; j < 20; j++) begin
      fb_ready = (j % 3 != 0);
      push(12'h600 + 12'(j), 8'h80 + 8'(j));
    end
    chk("wrap_lvl", fifo_level, 7);
    chk("wrap_ov", overflow, 0);
    fb_ready = 1'b1;
    drain("wrap_drain");

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
